// File: rtl/ewma_cov_engine.sv
// Streaming EWMA mean/covariance engine over N price channels (signed fixed point).
// Optional COV_SATURATE_EN: out-of-range stages clamp instead of wrapping.
module ewma_cov_engine #(
  parameter int N_ASSETS = 4,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int SHIFT_W  = 4
) (
  input  logic                         clk_100mhz,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic [SHIFT_W-1:0]           alpha_shift,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_ASSETS*DATA_W-1:0]   in_price,
  output logic                         out_valid,
  output logic [2:0]                   out_i,
  output logic [2:0]                   out_j,
  output logic [DATA_W-1:0]            out_cov,
  output logic                         out_last,
  output logic [N_ASSETS*DATA_W-1:0]   mean_bus,
  output logic                         overflow
);
  localparam int K  = N_ASSETS * (N_ASSETS + 1) / 2;
  localparam int IW = $clog2(N_ASSETS);
  localparam int KW = $clog2(K);
  localparam int WW = 2 * DATA_W + 2;

  typedef logic signed [WW-1:0]     wide_t;
  typedef logic signed [DATA_W-1:0] data_t;
  typedef enum logic [1:0] {IDLE, PRIME, MEAN, UPDATE} state_t;

  state_t             state, state_n;
  logic               primed;
  logic [SHIFT_W-1:0] s_q;
  logic [IW-1:0]      row, col;
  logic [KW-1:0]      kidx;
  data_t              pbuf_q [N_ASSETS];
  data_t              prev_q [N_ASSETS];
  data_t              mean_q [N_ASSETS];
  data_t              r_q    [N_ASSETS];
  data_t              m_q    [K];

  // Out of range when the bits above the DATA_W sign bit are not a pure sign extension.
  function automatic logic oor(input wide_t v);
    logic [WW-DATA_W:0] top;
    top = v[WW-1:DATA_W-1];
    return !((&top) || !(|top));
  endfunction

  function automatic data_t fit(input wide_t v);
`ifdef COV_SATURATE_EN
    if (oor(v))
      return v[WW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
    return v[DATA_W-1:0];
  endfunction

  data_t r_n [N_ASSETS];
  data_t mean_n [N_ASSETS];
  wide_t rw, dw, mw;
  data_t dd;
  logic  mean_ovf;

  always_comb begin
    mean_ovf = 1'b0;
    rw = '0;
    dw = '0;
    mw = '0;
    dd = '0;
    for (int unsigned c = 0; c < N_ASSETS; c++) begin
      rw        = wide_t'(pbuf_q[c]) - wide_t'(prev_q[c]);
      r_n[c]    = fit(rw);
      dw        = wide_t'(r_n[c]) - wide_t'(mean_q[c]);
      dd        = fit(dw);
      mw        = wide_t'(mean_q[c]) + (wide_t'(dd) >>> s_q);
      mean_n[c] = fit(mw);
      mean_ovf  = mean_ovf | oor(rw) | oor(dw) | oor(mw);
    end
  end

  wide_t qw, mw2, pw, cw;
  data_t q, m_new, mp, cov_n;
  logic  upd_ovf, last;

  always_comb begin
    qw      = (wide_t'(r_q[row]) * wide_t'(r_q[col])) >>> FRAC_W;
    q       = fit(qw);
    mw2     = wide_t'(m_q[kidx]) + ((wide_t'(q) - wide_t'(m_q[kidx])) >>> s_q);
    m_new   = fit(mw2);
    pw      = (wide_t'(mean_q[row]) * wide_t'(mean_q[col])) >>> FRAC_W;
    mp      = fit(pw);
    cw      = wide_t'(m_new) - wide_t'(mp);
    cov_n   = fit(cw);
    upd_ovf = oor(qw) | oor(mw2) | oor(pw) | oor(cw);
    last    = (row == IW'(N_ASSETS - 1));
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = primed ? MEAN : PRIME;
      PRIME:   state_n = IDLE;
      MEAN:    state_n = UPDATE;
      UPDATE:  if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end

  assign in_ready = (state == IDLE);

  always_comb begin
    mean_bus = '0;
    for (int unsigned c = 0; c < N_ASSETS; c++)
      mean_bus[c*DATA_W +: DATA_W] = mean_q[c];
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      primed    <= 1'b0;
      s_q       <= '0;
      row       <= '0;
      col       <= '0;
      kidx      <= '0;
      pbuf_q    <= '{default: '0};
      prev_q    <= '{default: '0};
      mean_q    <= '{default: '0};
      r_q       <= '{default: '0};
      m_q       <= '{default: '0};
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_i     <= '0;
      out_j     <= '0;
      out_cov   <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      primed    <= 1'b0;
      s_q       <= '0;
      row       <= '0;
      col       <= '0;
      kidx      <= '0;
      pbuf_q    <= '{default: '0};
      prev_q    <= '{default: '0};
      mean_q    <= '{default: '0};
      r_q       <= '{default: '0};
      m_q       <= '{default: '0};
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_i     <= '0;
      out_j     <= '0;
      out_cov   <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          s_q <= alpha_shift;
          for (int unsigned c = 0; c < N_ASSETS; c++)
            pbuf_q[c] <= in_price[c*DATA_W +: DATA_W];
        end
        PRIME: begin
          prev_q <= pbuf_q;
          primed <= 1'b1;
        end
        MEAN: begin
          r_q      <= r_n;
          mean_q   <= mean_n;
          prev_q   <= pbuf_q;
          row      <= '0;
          col      <= '0;
          kidx     <= '0;
          overflow <= overflow | mean_ovf;
        end
        UPDATE: begin
          m_q[kidx] <= m_new;
          out_valid <= 1'b1;
          out_i     <= 3'(row);
          out_j     <= 3'(col);
          out_cov   <= cov_n;
          out_last  <= last;
          overflow  <= overflow | upd_ovf;
          kidx      <= kidx + 1'b1;
          // Row-major walk of the upper triangle; each new row starts on its diagonal.
          if (last) begin
            row  <= '0;
            col  <= '0;
            kidx <= '0;
          end else if (col == IW'(N_ASSETS - 1)) begin
            row <= row + 1'b1;
            col <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ewma_cov_engine.sv
// Scoreboard bench for ewma_cov_engine: integer reference model feeds an expectation
// queue, an independent monitor pops and compares each covariance beat.
module tb_ewma_cov_engine;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int FW = 8;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            clear = 1'b0;
  logic [SW-1:0]   alpha_shift = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*DW-1:0] in_price = '0;
  logic            out_valid;
  logic [2:0]      out_i, out_j;
  logic [DW-1:0]   out_cov;
  logic            out_last;
  logic [N*DW-1:0] mean_bus;
  logic            overflow;

  always #5 clk = ~clk;

  ewma_cov_engine #(.N_ASSETS(N), .DATA_W(DW), .FRAC_W(FW), .SHIFT_W(SW)) dut (
    .clk_100mhz(clk), .reset_n(reset_n), .clear(clear), .alpha_shift(alpha_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_price(in_price),
    .out_valid(out_valid), .out_i(out_i), .out_j(out_j), .out_cov(out_cov),
    .out_last(out_last), .mean_bus(mean_bus), .overflow(overflow)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int     i;
    int     j;
    longint cov;
    bit     last;
  } exp_t;
  exp_t exp_q[$];

  bit     m_primed, m_ovf;
  longint m_prev[N], m_mean[N];
  longint m_mom[N][N];

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Range-limit to a DW-bit signed value, noting any excursion.
  function automatic longint fitm(input longint v);
    longint lim = 64'sd32768;
    if (v >= lim || v < -lim) m_ovf = 1'b1;
`ifdef COV_SATURATE_EN
    if (v >= lim) return lim - 1;
    if (v < -lim) return -lim;
    return v;
`else
    return ((v & 65535) >= lim) ? (v & 65535) - 65536 : (v & 65535);
`endif
  endfunction

  task automatic model_reset();
    m_primed = 1'b0;
    m_ovf    = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 0;
      m_mean[i] = 0;
      for (int j = 0; j < N; j++) m_mom[i][j] = 0;
    end
  endtask

  task automatic model_apply(input longint p[N], input int s);
    longint r[N];
    longint d, q, mp;
    exp_t   e;
    if (!m_primed) begin
      for (int i = 0; i < N; i++) m_prev[i] = p[i];
      m_primed = 1'b1;
      return;
    end
    for (int i = 0; i < N; i++) begin
      r[i]      = fitm(p[i] - m_prev[i]);
      d         = fitm(r[i] - m_mean[i]);
      m_mean[i] = fitm(m_mean[i] + (d >>> s));
      m_prev[i] = p[i];
    end
    for (int i = 0; i < N; i++)
      for (int j = i; j < N; j++) begin
        q           = fitm((r[i] * r[j]) >>> FW);
        m_mom[i][j] = fitm(m_mom[i][j] + ((q - m_mom[i][j]) >>> s));
        mp          = fitm((m_mean[i] * m_mean[j]) >>> FW);
        e.i         = i;
        e.j         = j;
        e.cov       = fitm(m_mom[i][j] - mp);
        e.last      = (i == N - 1) && (j == N - 1);
        exp_q.push_back(e);
      end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected out_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_i", longint'(out_i), e.i);
        chk("out_j", longint'(out_j), e.j);
        chk($sformatf("out_cov(%0d,%0d)", e.i, e.j), longint'($signed(out_cov)), e.cov);
        chk("out_last", longint'(out_last), longint'(e.last));
      end
    end
  end

  function automatic longint rnd_price();
    return longint'($urandom_range(3000)) - 1500;
  endfunction

  task automatic send(input longint p[N], input int s);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready wait timeout", 0, 1);
    in_valid    = 1'b1;
    alpha_shift = SW'(s);
    for (int c = 0; c < N; c++) in_price[c*DW +: DW] = p[c][DW-1:0];
    model_apply(p, s);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    alpha_shift = SW'($urandom);
    in_price    = {$urandom, $urandom};
    chk("in_ready busy after accept", longint'(in_ready), 0);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain pending beats", exp_q.size(), 0);
  endtask

  task automatic check_state(input string tag);
    for (int c = 0; c < N; c++)
      chk($sformatf("%s mean_bus[%0d]", tag, c), longint'($signed(mean_bus[c*DW +: DW])), m_mean[c]);
    chk({tag, " overflow"}, longint'(overflow), longint'(m_ovf));
  endtask

  task automatic do_clear(input bit with_valid);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = with_valid;
    in_price = {$urandom, $urandom};
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    model_reset();
    chk("in_ready after clear", longint'(in_ready), 1);
    chk("out_valid after clear", longint'(out_valid), 0);
    chk("out_last after clear", longint'(out_last), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " out_valid"}, longint'(out_valid), 0);
    chk({tag, " out_last"}, longint'(out_last), 0);
    chk({tag, " out_i"}, longint'(out_i), 0);
    chk({tag, " out_j"}, longint'(out_j), 0);
    chk({tag, " out_cov"}, longint'(out_cov), 0);
    chk({tag, " in_ready"}, longint'(in_ready), 1);
    chk({tag, " overflow"}, longint'(overflow), 0);
    chk({tag, " mean_bus"}, longint'(mean_bus == '0), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint pv[N];
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Priming only
    pv = '{256, 256, 256, 256};
    send(pv, 1);
    @(posedge clk);
    #1;
    chk("in_ready after prime", longint'(in_ready), 1);
    repeat (3) @(negedge clk);
    check_state("prime");

    // Basic update
    pv = '{512, 512, 512, 512};
    send(pv, 1);
    drain();
    check_state("basic");

    // alpha_shift = 0
    do_clear(1'b0);
    pv = '{0, 0, 0, 0};
    send(pv, 0);
    pv = '{256, -256, 512, 128};
    send(pv, 0);
    drain();
    check_state("s0");

    // Overflow, after a clear that coincides with in_valid
    do_clear(1'b1);
    pv = '{0, 0, 0, 0};
    send(pv, 1);
    repeat (3) @(negedge clk);
    pv = '{32767, 0, 0, 0};
    send(pv, 1);
    drain();
    check_state("ovf");
    send(pv, 1);
    drain();
    check_state("ovf sticky");
    do_clear(1'b0);
    check_state("ovf cleared");

    // Clear on the 4th beat
    for (int c = 0; c < N; c++) pv[c] = rnd_price();
    send(pv, 2);
    for (int c = 0; c < N; c++) pv[c] = rnd_price();
    send(pv, 2);
    repeat (5) @(posedge clk);
    #1;
    chk("4th beat present", longint'(out_valid), 1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    exp_q.delete();
    model_reset();
    chk("mid clear out_valid", longint'(out_valid), 0);
    chk("mid clear out_last", longint'(out_last), 0);
    check_state("mid clear");
    for (int c = 0; c < N; c++) pv[c] = rnd_price();
    send(pv, 3);
    repeat (4) @(negedge clk);
    for (int c = 0; c < N; c++) pv[c] = rnd_price();
    send(pv, 3);
    drain();
    check_state("after clear");

    // Async reset mid-update
    for (int c = 0; c < N; c++) pv[c] = rnd_price();
    send(pv, 1);
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    model_reset();
    check_reset_outputs("async reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < N; c++) pv[c] = rnd_price();
    send(pv, 2);
    repeat (4) @(negedge clk);
    for (int c = 0; c < N; c++) pv[c] = rnd_price();
    send(pv, 2);
    drain();
    check_state("after reset");

    // Random updates
    for (int k = 0; k < 20; k++) begin
      for (int c = 0; c < N; c++) pv[c] = rnd_price();
      send(pv, int'($urandom_range(6)));
      drain();
      check_state($sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ewma_cov_engine.md
Name: ewma_cov_engine

Overview:
- Streaming covariance engine for N price channels, Q(W-F).F signed fixed point.
- Holds previous price, running means and second moments internally; the caller no longer carries them.
- Per accepted price vector: forms returns, updates EWMA mean and moment, streams the upper-triangle covariance one element per cycle.
- Sits between the price feed and the portfolio/risk stage; successor to the fixed 4-asset update_cov.

Parameters:
N_ASSETS, 4, channel count (2..8)
DATA_W, 16, signed data width
FRAC_W, 8, fractional bits
SHIFT_W, 4, width of alpha_shift

Ports:
clk_100mhz  in  1  system clock
reset_n  in  1  async active-low reset
clear  in  1  sync clear of all statistics, priming state and overflow
alpha_shift  in  SHIFT_W  EWMA weight 2^-alpha_shift; sampled on accept
in_valid  in  1  price vector valid
in_ready  out  1  engine can accept
in_price  in  N_ASSETS*DATA_W  channel i at [i*DATA_W +: DATA_W]
out_valid  out  1  covariance element valid (no backpressure)
out_i  out  3  row index
out_j  out  3  column index, j>=i
out_cov  out  DATA_W  cov[i][j]
out_last  out  1  last element of the update
mean_bus  out  N_ASSETS*DATA_W  current means, same packing as in_price
overflow  out  1  sticky overflow flag

Behaviour:
- Reset (async, reset_n=0): FSM IDLE, unprimed; all means, moments and prev price 0; in_ready=1; out_valid=0, out_last=0, out_i/out_j/out_cov=0; overflow=0.
- Handshake: accept on in_valid && in_ready. in_ready=1 only in IDLE.
- States: IDLE -> (accept, unprimed) PRIME -> IDLE; IDLE -> (accept, primed) MEAN -> UPDATE -> IDLE.
- PRIME, 1 cycle: latch prev=in_price; set primed; no output.
- MEAN, 1 cycle, all channels in parallel: r_i=p_i-prev_i; d_i=r_i-mean_i; mean_i += d_i>>>s; prev=p. Store r_i.
- UPDATE: K=N(N+1)/2 cycles, row-major upper triangle (0,0),(0,1)..(0,N-1),(1,1)..(N-1,N-1). Per cycle one pair:
  - q = (r_i*r_j)>>>F
  - m_ij += (q-m_ij)>>>s
  - out_cov = m_ij(new) - ((mean_i*mean_j)>>>F), using the updated means.
  - Outputs registered; out_valid=1 that cycle.
  - out_last=1 on (N-1,N-1); FSM returns to IDLE the next cycle.
- Latency: element (0,0) valid 2 cycles after accept; next accept possible K+2 cycles after previous accept.
- Arithmetic:
  - Products full 2*DATA_W, arithmetic right shift by FRAC_W (floor).
  - Each stage (r, d, q, m update, mean product, cov) range-checked against DATA_W signed.
  - Any out-of-range value sets overflow; it stays set until clear or reset.
- Only upper triangle stored (K moment registers); symmetry is the consumer's job.
- alpha_shift=0: mean=r, m=q, so cov=0 up to rounding.
- clear: in any state returns to IDLE unprimed, zeroes state, drops any in-flight update (out_valid=0 next cycle). clear with in_valid in the same cycle: clear wins, sample dropped, in_ready stays 1.
- reset_n deasserted mid-UPDATE: immediate return to reset values; no partial out_last.
- in_price ignored outside an accept cycle.

Optional Feature:
- COV_SATURATE_EN
- Defined: every overflowing stage clamps to +2^(DATA_W-1)-1 or -2^(DATA_W-1) before use or storage.
- Undefined: two's-complement wrap to DATA_W bits.
- overflow flag behaves identically either way.

Test Plan:
- Priming: reset, send p=all 256 -> no out_valid; in_ready returns 1 next cycle; mean_bus all 0.
- Basic update: s=1, prime all 256, then all 512 -> 10 beats in row-major order, each out_cov=64; mean_bus all 128; out_last only on (3,3); overflow=0.
- s=0 sweep: prime 0, then {256,-256,512,128} -> all out_cov=0; mean_bus={256,-256,512,128}.
- Overflow: s=1, prime 0, then ch0=32767, others 0 -> overflow=1. With COV_SATURATE_EN, (0,0) out_cov=-16384. Flag still 1 after a later benign update; cleared by clear.
- Clear mid-UPDATE: pulse clear on the 4th beat -> out_valid=0 next cycle, no out_last; next sample only primes.
- Async reset mid-UPDATE: drop reset_n between clock edges -> outputs return to reset values immediately; next accepted sample primes only.
